// File: rtl/param_tick_counter.sv
// param_tick_counter: WIDTH-bit LED counter advanced by a single-cycle tick
// from an internal clk divider, or by a synchronised step button.
// Modes: up, down, bounce, manual step. Wrap or saturate at the ends,
// synchronous load with clamping to MAX_VAL. Everything runs on clk; the
// divider only produces an enable strobe, never a derived clock.
//
// Parameter ranges the design relies on:
//   WIDTH >= 2, 1 <= MAX_VAL <= 2**WIDTH-1, DIV_COUNT >= 2, SYNC_STAGES >= 2.

module param_tick_counter #(
  parameter int WIDTH       = 4,
  parameter int MAX_VAL     = 15,
  parameter int DIV_COUNT   = 12000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_button,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             wrap,
  input  logic             step_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] led,
  output logic             tick,
  output logic             tc,
  output logic             dir
);

  // Divider width: ceil(log2(DIV_COUNT)) bits, enough for 0..DIV_COUNT-1.
  localparam int DIV_W = $clog2(DIV_COUNT);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_M1   = WIDTH'(MAX_VAL - 1);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_STEP   = 2'b11;

  // ---------------------------------------------------------------------
  // Tick divider
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic             rollover;

  // Rollover is the edge that ends a DIV_COUNT-cycle period; en=0 freezes it.
  assign rollover = en & (div_cnt == DIV_LAST);

  // Divider count and registered tick strobe (high the cycle after rollover).
  always_ff @(posedge clk or negedge rst_button) begin
    if (!rst_button) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (rollover) begin
        div_cnt <= '0;
        tick    <= 1'b1;
      end else if (en) begin
        div_cnt <= div_cnt + DIV_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Step button synchroniser and falling-edge detect
  // ---------------------------------------------------------------------
  // sync_q shifts step_n in at bit 0; the last stage is the clean sample.
  // step_prev holds the previous clean sample for edge detection.
  // arm_q fills with ones after reset; until it is full, step_prev and the
  // last sync stage still carry reset values rather than real samples, so
  // a button held low through reset cannot masquerade as a new press.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   step_prev;
  logic [SYNC_STAGES:0]   arm_q;
  logic                   step_synced;
  logic                   step_pulse;

  assign step_synced = sync_q[SYNC_STAGES-1];

  // One-cycle pulse on a high-to-low transition of the synchronised button.
  assign step_pulse = arm_q[SYNC_STAGES] & step_prev & ~step_synced;

  // Synchroniser chain, edge-detect history and post-reset arming shifter.
  always_ff @(posedge clk or negedge rst_button) begin
    if (!rst_button) begin
      sync_q    <= '1;
      step_prev <= 1'b1;
      arm_q     <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], step_n};
      step_prev <= step_synced;
      arm_q     <= {arm_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // ---------------------------------------------------------------------
  // Counter state machine: value, direction and terminal-count pulse
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             tc_q,  tc_d;
  logic             advance;
  logic [WIDTH-1:0] load_clamped;

  // Manual mode listens only to the button; every other mode to the divider.
  assign advance = (mode == MODE_STEP) ? step_pulse : rollover;

  // A load never places the counter above the terminal value.
  assign load_clamped = (load_val > MAX_W) ? MAX_W : load_val;

  // State register: counter value, direction and tc.
  always_ff @(posedge clk or negedge rst_button) begin
    if (!rst_button) begin
      cnt_q <= '0;
      dir_q <= 1'b1;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      tc_q  <= tc_d;
    end
  end

  // Next state: load beats advance beats hold; tc only on a boundary advance.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    tc_d  = 1'b0;
    if (load) begin
      // The coincident advance, if any, is dropped; dir stays as it was.
      cnt_d = load_clamped;
    end else if (advance) begin
      case (mode)
        MODE_UP, MODE_STEP: begin
          dir_d = 1'b1;
          if (cnt_q < MAX_W) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            tc_d  = 1'b1;
            cnt_d = wrap ? CNT_ZERO : MAX_W;
          end
        end
        MODE_DOWN: begin
          dir_d = 1'b0;
          if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            tc_d  = 1'b1;
            cnt_d = wrap ? MAX_W : CNT_ZERO;
          end
        end
        MODE_BOUNCE: begin
          // Bounce reflects at both ends and never wraps or saturates.
          if (dir_q) begin
            if (cnt_q >= MAX_W) begin
              dir_d = 1'b0;
              cnt_d = MAX_M1;
              tc_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            if (cnt_q == CNT_ZERO) begin
              dir_d = 1'b1;
              cnt_d = CNT_ONE;
              tc_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  // Outputs come straight from the state registers (glitch-free LEDs).
  always_comb begin
    led = cnt_q;
    dir = dir_q;
    tc  = tc_q;
  end

endmodule

// File: tb/tb_param_tick_counter.sv
// Directed bench for param_tick_counter with WIDTH=4, MAX_VAL=9,
// DIV_COUNT=4, SYNC_STAGES=2. Inputs change and outputs are sampled on the
// falling clk edge; the divider is kept aligned so that a tick is visible
// every fourth falling edge after each alignment point.

module tb_param_tick_counter;

  localparam int WIDTH       = 4;
  localparam int MAX_VAL     = 9;
  localparam int DIV_COUNT   = 4;
  localparam int SYNC_STAGES = 2;

  // ---------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             rst_button;
  logic             en;
  logic [1:0]       mode;
  logic             wrap;
  logic             step_n;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] led;
  logic             tick;
  logic             tc;
  logic             dir;

  always #5 clk = ~clk;

  param_tick_counter #(
    .WIDTH      (WIDTH),
    .MAX_VAL    (MAX_VAL),
    .DIV_COUNT  (DIV_COUNT),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst_button(rst_button),
    .en        (en),
    .mode      (mode),
    .wrap      (wrap),
    .step_n    (step_n),
    .load      (load),
    .load_val  (load_val),
    .led       (led),
    .tick      (tick),
    .tc        (tc),
    .dir       (dir)
  );

  // ---------------------------------------------------------------------
  // Scoreboard counters and checking task
  // ---------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic nedge(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset for one full cycle; returns on the falling edge of release,
  // where the divider count is 0.
  task automatic apply_reset();
    @(negedge clk);
    rst_button = 1'b0;
    @(negedge clk);
    rst_button = 1'b1;
  endtask

  // Expected bounce sequence starting from led=8, dir=1.
  int bn_led[11];
  int bn_dir[11];
  int bn_tc[11];

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    bn_led = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    bn_dir = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    bn_tc  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    rst_button = 1'b0;
    en         = 1'b1;
    mode       = 2'b00;
    wrap       = 1'b1;
    step_n     = 1'b1;
    load       = 1'b0;
    load_val   = '0;

    // Reset state
    nedge(2);
    check("rst_led", led, 0);
    check("rst_dir", dir, 1);
    check("rst_tick", tick, 0);
    check("rst_tc", tc, 0);
    rst_button = 1'b1;

    // Up, wrap: 1..9 then 0, tick period 4, tc only on 9->0
    for (int i = 1; i <= 10; i++) begin
      nedge(3);
      check("up_gap_tick", tick, 0);
      check("up_gap_tc", tc, 0);
      nedge(1);
      check("up_led", led, i % 10);
      check("up_tick", tick, 1);
      check("up_tc", tc, (i == 10) ? 1 : 0);
    end
    check("up_dir", dir, 1);

    // Up, saturate: climbs to 9 and then pulses tc on every tick
    wrap = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      nedge(4);
      check("sat_led", led, (i < 9) ? i : 9);
      check("sat_tc", tc, (i >= 10) ? 1 : 0);
    end

    // Down, wrap from 2: 1, 0, 9
    mode     = 2'b01;
    wrap     = 1'b1;
    load     = 1'b1;
    load_val = 4'd2;
    nedge(1);
    load = 1'b0;
    check("dn_load_led", led, 2);
    check("dn_load_keeps_dir", dir, 1);
    nedge(3);
    check("dn_led1", led, 1);
    check("dn_dir", dir, 0);
    check("dn_tc1", tc, 0);
    nedge(4);
    check("dn_led0", led, 0);
    check("dn_tc0", tc, 0);
    nedge(4);
    check("dn_wrap_led", led, 9);
    check("dn_wrap_tc", tc, 1);
    check("dn_wrap_dir", dir, 0);

    // Freeze the divider mid-count (count=2) for 10 cycles
    nedge(2);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      nedge(1);
      check("frz_tick", tick, 0);
    end
    check("frz_led", led, 9);
    en = 1'b1;
    nedge(1);
    check("frz_resume_tick0", tick, 0);
    nedge(1);
    check("frz_resume_tick1", tick, 1);
    check("frz_resume_led", led, 8);
    check("frz_resume_tc", tc, 0);

    // Asynchronous reset mid-count at led=5, dir=0
    load     = 1'b1;
    load_val = 4'd5;
    nedge(1);
    load = 1'b0;
    check("mid_led5", led, 5);
    check("mid_dir0", dir, 0);
    nedge(1);
    #2 rst_button = 1'b0;
    #1;
    check("arst_led", led, 0);
    check("arst_dir", dir, 1);
    check("arst_tick", tick, 0);
    check("arst_tc", tc, 0);
    @(negedge clk);
    rst_button = 1'b1;
    nedge(3);
    check("arst_div_restart", tick, 0);
    nedge(1);
    check("arst_first_tick", tick, 1);
    check("arst_dn_led", led, 9);
    check("arst_dn_tc", tc, 1);

    // Bounce from led=8, dir=1
    apply_reset();
    mode     = 2'b10;
    load     = 1'b1;
    load_val = 4'd8;
    nedge(1);
    load = 1'b0;
    check("bn_load_led", led, 8);
    check("bn_load_dir", dir, 1);
    nedge(3);
    for (int k = 0; k < 11; k++) begin
      if (k != 0) nedge(4);
      check("bn_led", led, bn_led[k]);
      check("bn_dir", dir, bn_dir[k]);
      check("bn_tc", tc, bn_tc[k]);
    end

    // Manual: step_n low 20 cycles -> one increment, 3 edges after the fall
    mode   = 2'b11;
    step_n = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      nedge(1);
      check("man_led", led, (k >= 3) ? 2 : 1);
      check("man_tc", tc, 0);
      check("man_tick_runs", tick, (k % 4 == 0) ? 1 : 0);
    end
    step_n = 1'b1;
    nedge(5);
    check("man_release_led", led, 2);

    // Manual wrap at MAX_VAL
    load     = 1'b1;
    load_val = 4'd9;
    nedge(1);
    load   = 1'b0;
    step_n = 1'b0;
    nedge(2);
    check("man_pre_wrap_led", led, 9);
    nedge(1);
    check("man_wrap_led", led, 0);
    check("man_wrap_tc", tc, 1);
    check("man_wrap_dir", dir, 1);
    nedge(1);
    check("man_wrap_tc_clear", tc, 0);

    // Button held low across reset: no step until released and pressed again
    apply_reset();
    nedge(10);
    check("held_reset_no_step", led, 0);
    step_n = 1'b1;
    nedge(4);
    step_n = 1'b0;
    nedge(2);
    check("repress_latency", led, 0);
    nedge(1);
    check("repress_led", led, 1);
    step_n = 1'b1;

    // Load clamping, then load coinciding with a tick at the terminal value
    mode = 2'b00;
    wrap = 1'b1;
    apply_reset();
    load     = 1'b1;
    load_val = 4'd12;
    nedge(1);
    load = 1'b0;
    check("load_clamp_led", led, 9);
    nedge(2);
    load     = 1'b1;
    load_val = 4'd6;
    nedge(1);
    load = 1'b0;
    check("load_tick_led", led, 6);
    check("load_tick_tc", tc, 0);
    check("load_tick_tick", tick, 1);
    nedge(4);
    check("after_load_led", led, 7);
    check("after_load_tc", tc, 0);
    check("after_load_tick", tick, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
